lt24_bus_responder: RTL and testbench
=====================================

// Module: lt24_bus_responder
// PURPOSE
//  Panel-side end of the LT24 8080-style write bus: decodes the cs_n/dc_n/wr_n/rd_n/d traffic from the LT24 controller
//  as an ILI9341 would and emits addressed pixel writes (x, y, RGB565) through a valid/ready stream.
//  Used as an in-fabric panel emulator (framebuffer capture, loopback checks) alongside the LT24 controller in soc_system.
// PARAMETERS
//  H_RES        240        column count; column end address clamps to H_RES-1
//  V_RES        320        row count; page end address clamps to V_RES-1
//  SYNC_STAGES  2          synchroniser flops on every bus input (>=2)
//  FIFO_DEPTH   4          pixel output FIFO entries (power of 2)
// PORTS
//  clk          in   1   single clock; all logic synchronous to it
//  reset_n      in   1   asynchronous, active-low reset
//  lcd_cs_n     in   1   bus chip select, active low
//  lcd_dc_n     in   1   0 = command byte, 1 = data word
//  lcd_wr_n     in   1   write strobe; data is captured on the rising edge
//  lcd_rd_n     in   1   read strobe; used only with LT24_RESP_READ_EN
//  lcd_d        in   16  bus data; a command uses d[7:0]
//  lcd_reset_n  in   1   panel reset from the controller, active low
//  lcd_d_out    out  16  read return data (LT24_RESP_READ_EN; otherwise 0)
//  lcd_d_oe     out  1   read data enable (LT24_RESP_READ_EN; otherwise 0)
//  pix_valid    out  1   pixel available at the FIFO head
//  pix_ready    in   1   consumer accepts the pixel when pix_valid && pix_ready
//  pix_x        out  9   pixel column
//  pix_y        out  9   pixel row
//  pix_data     out  16  RGB565 pixel value
//  disp_on      out  1   set by 0x29, cleared by 0x28/0x01/reset
//  overflow     out  1   sticky: a pixel was dropped because the FIFO was full; cleared only by reset/0x01
// BEHAVIOUR
//  Reset: all outputs 0. Window defaults: SC=0, EC=H_RES-1, SP=0, EP=V_RES-1. State IDLE. FIFO empty.
//  Strobe: a write event fires on the cycle the synchronised wr_n goes 0->1 while synchronised cs_n=0.
//   The bus is sampled from the last synchronised stage.
//  Latency: pix_valid rises SYNC_STAGES+2 clk after the wr_n rising edge at the pins (4 clk by default)
//   when the FIFO was empty.
//  FSM:
//   IDLE, CASET_P0..P3, PASET_P0..P3, RAMWR.
//   Command write (dc_n=0) from any state, d[7:0]:
//    0x2A -> CASET_P0
//    0x2B -> PASET_P0
//    0x2C -> RAMWR, pointer=(SC,SP)
//    0x3C -> RAMWR, pointer kept
//    0x29/0x28 -> set/clear disp_on, IDLE
//    0x01 -> window/overflow/disp_on to reset values, FIFO flushed, IDLE
//    anything else -> IDLE
//   A command arriving mid CASET/PASET aborts it; the window registers stay unchanged.
//   Param writes (dc_n=1): P0=hi byte of start, P1=lo byte of start, P2=hi byte of end, P3=lo byte of end (d[7:0]).
//    The window commits only on P3.
//    On commit, end>=RES clamps to RES-1; start>end sets end:=start (start clamped first).
//    After P3 -> IDLE.
//   RAMWR data write: push {x,y,d} and advance x.
//    x==EC wraps x:=SC, y++. y==EP at that wrap sets y:=SP.
//   Data write in IDLE: ignored.
//  FIFO full on push: pixel dropped, pointer still advances, overflow:=1.
//   A simultaneous pop frees the slot, so the push succeeds.
//  lcd_reset_n low (synchronised) acts as 0x01 plus FSM to IDLE for as long as it is held.
//  A reset_n assertion mid-stream discards everything immediately.
//  rd_n falling edges are ignored without the macro.
// CONFIGURATION
//  LT24_RESP_READ_EN defined:
//   Command 0xD3 (RDID4) arms reads. Each subsequent rd_n low with cs_n=0, dc_n=1 returns, in order:
//    0x0000, 0x0000, 0x0093, 0x0041.
//   lcd_d_oe=1 is driven from the synchronised rd_n falling edge until its rising edge. A fifth read returns 0x0000.
//   The next command disarms.
//  Not defined: lcd_d_out=0, lcd_d_oe=0, no read logic.
// STRUCTURE
//  Package lt24_pkg: command opcodes (CMD_CASET=0x2A, CMD_PASET, CMD_RAMWR, CMD_RAMWRC, CMD_DISPON, CMD_DISPOFF,
//   CMD_SWRESET, CMD_RDID4), FSM state enum, pixel struct {x[8:0], y[8:0], rgb[15:0]}.
//  Sub-module lt24_pix_fifo: synchronous FIFO, FIFO_DEPTH entries of the pixel struct, with full/empty and
//   same-cycle push/pop.
//  Synchronisers and the FSM live in the top module.
// TESTING
//  1. Reset, 0x2C, 3 data writes 0xF800/0x07E0/0x001F with pix_ready=1
//     -> pixels (0,0),(1,0),(2,0) carry those values; first pix_valid 4 clk after the first wr_n rise.
//  2. CASET 0,10,0,11; PASET 0,5,0,6; RAMWR with 5 writes
//     -> coordinates (10,5),(11,5),(10,6),(11,6),(10,5).
//  3. CASET 0x01,0x00,0x01,0x20 (start 256, end 288)
//     -> start clamps to 239, end to 239; RAMWR gives x=239 for every pixel.
//  4. pix_ready=0, 6 RAMWR writes with FIFO_DEPTH=4
//     -> 4 held, overflow=1; releasing ready yields 4 pixels in order, x=0..3.
//  5. CASET with 2 params, then 0x2C, then 1 write
//     -> window unchanged, pixel at (0,0).
//     Pulse lcd_reset_n mid-RAMWR -> FIFO empty, disp_on=0.
//  6. (LT24_RESP_READ_EN) 0xD3 followed by 4 rd_n pulses
//     -> lcd_d_out 0x0000,0x0000,0x0093,0x0041 with lcd_d_oe high during each; without the macro, lcd_d_oe stays 0.

Source files
------------

// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 panel-side bus responder.
//  - ILI9341 command opcodes understood by the responder
//  - FSM state encoding
//  - pixel record carried through the output FIFO
//  - small helpers for window clamping and RDID4 read data
package lt24_pkg;

    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_RDID4   = 8'hD3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CASET_P0 = 4'd1,
        ST_CASET_P1 = 4'd2,
        ST_CASET_P2 = 4'd3,
        ST_CASET_P3 = 4'd4,
        ST_PASET_P0 = 4'd5,
        ST_PASET_P1 = 4'd6,
        ST_PASET_P2 = 4'd7,
        ST_PASET_P3 = 4'd8,
        ST_RAMWR    = 4'd9
    } lt24_state_e;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] rgb;
    } lt24_pix_t;

    localparam lt24_pix_t PIX_ZERO = '{x: 9'd0, y: 9'd0, rgb: 16'h0000};

    // Limit a 16-bit window address to the last valid line/column.
    function automatic logic [8:0] clamp_coord(input logic [15:0] v, input logic [15:0] lim);
        logic [8:0] r;
        if (v > lim) begin
            r = lim[8:0];
        end else begin
            r = v[8:0];
        end
        return r;
    endfunction

    // RDID4 returns a fixed four-word identification sequence, then zeros.
    function automatic logic [15:0] rdid4_word(input logic [2:0] idx);
        logic [15:0] r;
        case (idx)
            3'd2:    r = 16'h0093;
            3'd3:    r = 16'h0041;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lt24_pix_fifo.sv
// Synchronous pixel FIFO for the LT24 responder.
//  i_clk/i_reset_n : clock, async active-low reset
//  i_flush         : synchronous empty (takes priority over push/pop)
//  i_push/i_push_data : write request and pixel
//  i_pop           : read request (ignored when empty)
//  o_head          : pixel at the FIFO head
//  o_full/o_empty  : occupancy flags
//  o_drop          : a push was refused because the FIFO was full
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module lt24_pix_fifo
    import lt24_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    input  logic      i_flush,
    input  logic      i_push,
    input  lt24_pix_t i_push_data,
    input  logic      i_pop,
    output lt24_pix_t o_head,
    output logic      o_full,
    output logic      o_empty,
    output logic      o_drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    lt24_pix_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full    = (r_count == CNT_MAX);
    assign o_empty   = (r_count == (AW+1)'(0));
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    assign o_drop    = i_push && !i_flush && o_full && !w_do_pop;
    assign o_head    = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Pixel storage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PIX_ZERO;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/lt24_bus_responder.sv
// Panel-side emulator of an ILI9341 on the LT24 8080-style bus.
// Decodes cs_n/dc_n/wr_n/d writes into addressed RGB565 pixel writes
// presented through a valid/ready stream (pix_valid/pix_ready, pix_x/y/data).
// Ports: clk, reset_n (async active-low); lcd_cs_n, lcd_dc_n, lcd_wr_n,
// lcd_rd_n, lcd_d[15:0], lcd_reset_n (bus, asynchronous to clk);
// lcd_d_out/lcd_d_oe (read return); pix_* stream; disp_on; overflow (sticky).
// Optional feature macro: LT24_RESP_READ_EN enables RDID4 (0xD3) read-back.
module lt24_bus_responder
    import lt24_pkg::*;
#(
    parameter int H_RES       = 240,
    parameter int V_RES       = 320,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lcd_cs_n,
    input  logic        lcd_dc_n,
    input  logic        lcd_wr_n,
    input  logic        lcd_rd_n,
    input  logic [15:0] lcd_d,
    input  logic        lcd_reset_n,
    output logic [15:0] lcd_d_out,
    output logic        lcd_d_oe,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        disp_on,
    output logic        overflow
);
    localparam logic [8:0]  EC_RST = 9'(H_RES - 1);
    localparam logic [8:0]  EP_RST = 9'(V_RES - 1);
    localparam logic [15:0] H_LIM  = 16'(H_RES - 1);
    localparam logic [15:0] V_LIM  = 16'(V_RES - 1);

    // control sync bits: {lcd_reset_n, wr_n, dc_n, cs_n}
    logic [3:0]  r_ctl_sync [SYNC_STAGES];
    logic [15:0] r_d_sync   [SYNC_STAGES];
    logic        r_wr_prev;
    logic        r_evt;
    logic        r_evt_dc_n;
    logic [15:0] r_evt_d;
    lt24_state_e r_state;
    lt24_state_e w_state_nxt;
    logic [15:0] r_p_start;
    logic [7:0]  r_p_end_hi;
    logic [8:0]  r_sc, r_ec, r_sp, r_ep, r_x, r_y;
    logic        r_disp_on, r_overflow;

    logic        w_cs_n, w_dc_n, w_wr_n, w_lrst, w_wr_rise;
    logic        w_push, w_soft_rst, w_set_ptr, w_disp_set, w_disp_clr;
    logic        w_ld_p0, w_ld_p1, w_ld_p2, w_commit_c, w_commit_p;
    logic [15:0] w_lim;
    logic [8:0]  w_win_start, w_win_end_raw, w_win_end;
    lt24_pix_t   w_head;
    logic        w_full, w_empty, w_drop, w_pop;

    assign w_cs_n    = r_ctl_sync[SYNC_STAGES-1][0];
    assign w_dc_n    = r_ctl_sync[SYNC_STAGES-1][1];
    assign w_wr_n    = r_ctl_sync[SYNC_STAGES-1][2];
    assign w_lrst    = ~r_ctl_sync[SYNC_STAGES-1][3];
    assign w_wr_rise = w_wr_n && !r_wr_prev && !w_cs_n;

    // Input synchronisers; control lines idle high so reset cannot fake a strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_ctl_sync[i] <= 4'b1111;
                r_d_sync[i]   <= 16'h0000;
            end
            r_wr_prev <= 1'b1;
        end else begin
            r_ctl_sync[0] <= {lcd_reset_n, lcd_wr_n, lcd_dc_n, lcd_cs_n};
            r_d_sync[0]   <= lcd_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_ctl_sync[i] <= r_ctl_sync[i-1];
                r_d_sync[i]   <= r_d_sync[i-1];
            end
            r_wr_prev <= w_wr_n;
        end
    end

    // Captured write event; this stage sets the strobe-to-pixel latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evt      <= 1'b0;
            r_evt_dc_n <= 1'b0;
            r_evt_d    <= 16'h0000;
        end else begin
            r_evt      <= w_wr_rise;
            r_evt_dc_n <= w_dc_n;
            r_evt_d    <= r_d_sync[SYNC_STAGES-1];
        end
    end

`ifdef LT24_RESP_READ_EN
    logic w_arm, w_disarm;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and command/parameter decode.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_soft_rst  = 1'b0;
        w_set_ptr   = 1'b0;
        w_disp_set  = 1'b0;
        w_disp_clr  = 1'b0;
        w_ld_p0     = 1'b0;
        w_ld_p1     = 1'b0;
        w_ld_p2     = 1'b0;
        w_commit_c  = 1'b0;
        w_commit_p  = 1'b0;
`ifdef LT24_RESP_READ_EN
        w_arm       = 1'b0;
        w_disarm    = 1'b0;
`endif
        if (w_lrst) begin
            w_state_nxt = ST_IDLE;
            w_soft_rst  = 1'b1;
        end else if (r_evt && !r_evt_dc_n) begin
`ifdef LT24_RESP_READ_EN
            w_disarm = 1'b1;
`endif
            case (r_evt_d[7:0])
                CMD_CASET:   w_state_nxt = ST_CASET_P0;
                CMD_PASET:   w_state_nxt = ST_PASET_P0;
                CMD_RAMWR: begin
                    w_state_nxt = ST_RAMWR;
                    w_set_ptr   = 1'b1;
                end
                CMD_RAMWRC:  w_state_nxt = ST_RAMWR;
                CMD_DISPON: begin
                    w_state_nxt = ST_IDLE;
                    w_disp_set  = 1'b1;
                end
                CMD_DISPOFF: begin
                    w_state_nxt = ST_IDLE;
                    w_disp_clr  = 1'b1;
                end
                CMD_SWRESET: begin
                    w_state_nxt = ST_IDLE;
                    w_soft_rst  = 1'b1;
                end
`ifdef LT24_RESP_READ_EN
                CMD_RDID4: begin
                    w_state_nxt = ST_IDLE;
                    w_arm       = 1'b1;
                end
`endif
                default:     w_state_nxt = ST_IDLE;
            endcase
        end else if (r_evt) begin
            case (r_state)
                ST_CASET_P0: begin w_ld_p0 = 1'b1; w_state_nxt = ST_CASET_P1; end
                ST_CASET_P1: begin w_ld_p1 = 1'b1; w_state_nxt = ST_CASET_P2; end
                ST_CASET_P2: begin w_ld_p2 = 1'b1; w_state_nxt = ST_CASET_P3; end
                ST_CASET_P3: begin w_commit_c = 1'b1; w_state_nxt = ST_IDLE; end
                ST_PASET_P0: begin w_ld_p0 = 1'b1; w_state_nxt = ST_PASET_P1; end
                ST_PASET_P1: begin w_ld_p1 = 1'b1; w_state_nxt = ST_PASET_P2; end
                ST_PASET_P2: begin w_ld_p2 = 1'b1; w_state_nxt = ST_PASET_P3; end
                ST_PASET_P3: begin w_commit_p = 1'b1; w_state_nxt = ST_IDLE; end
                ST_RAMWR:    w_push = 1'b1;
                default:     w_state_nxt = r_state;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Window commit value: clamp both ends, then never let end precede start.
    always_comb begin
        w_lim         = w_commit_c ? H_LIM : V_LIM;
        w_win_start   = clamp_coord(r_p_start, w_lim);
        w_win_end_raw = clamp_coord({r_p_end_hi, r_evt_d[7:0]}, w_lim);
        w_win_end     = (w_win_end_raw < w_win_start) ? w_win_start : w_win_end_raw;
    end

    // Window, pointer, parameter and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p_start  <= 16'h0000;
            r_p_end_hi <= 8'h00;
            r_sc       <= 9'd0;
            r_ec       <= EC_RST;
            r_sp       <= 9'd0;
            r_ep       <= EP_RST;
            r_x        <= 9'd0;
            r_y        <= 9'd0;
            r_disp_on  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_soft_rst) begin
            r_sc       <= 9'd0;
            r_ec       <= EC_RST;
            r_sp       <= 9'd0;
            r_ep       <= EP_RST;
            r_x        <= 9'd0;
            r_y        <= 9'd0;
            r_disp_on  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ld_p0) r_p_start[15:8] <= r_evt_d[7:0];
            if (w_ld_p1) r_p_start[7:0]  <= r_evt_d[7:0];
            if (w_ld_p2) r_p_end_hi      <= r_evt_d[7:0];
            if (w_commit_c) begin
                r_sc <= w_win_start;
                r_ec <= w_win_end;
            end
            if (w_commit_p) begin
                r_sp <= w_win_start;
                r_ep <= w_win_end;
            end
            // The pointer advances even when the FIFO drops the pixel.
            if (w_set_ptr) begin
                r_x <= r_sc;
                r_y <= r_sp;
            end else if (w_push) begin
                if (r_x == r_ec) begin
                    r_x <= r_sc;
                    r_y <= (r_y == r_ep) ? r_sp : r_y + 9'd1;
                end else begin
                    r_x <= r_x + 9'd1;
                end
            end
            if (w_disp_set) begin
                r_disp_on <= 1'b1;
            end else if (w_disp_clr) begin
                r_disp_on <= 1'b0;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign w_pop = pix_ready && !w_empty;

    lt24_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_flush     (w_soft_rst),
        .i_push      (w_push),
        .i_push_data ('{x: r_x, y: r_y, rgb: r_evt_d}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_drop      (w_drop)
    );

    assign pix_valid = !w_empty;
    assign pix_x     = w_head.x;
    assign pix_y     = w_head.y;
    assign pix_data  = w_head.rgb;
    assign disp_on   = r_disp_on;
    assign overflow  = r_overflow;

`ifdef LT24_RESP_READ_EN
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic                   r_rd_prev, r_rd_armed, r_oe;
    logic [2:0]             r_rd_idx;
    logic [15:0]            r_dout;
    logic                   w_rd_n, w_rd_fall, w_rd_rise;

    assign w_rd_n    = r_rd_sync[SYNC_STAGES-1];
    assign w_rd_fall = !w_rd_n && r_rd_prev && !w_cs_n && w_dc_n && r_rd_armed;
    assign w_rd_rise = w_rd_n && !r_rd_prev;

    // RDID4 read-back: arm on 0xD3, drive one word per rd_n low pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_sync  <= {SYNC_STAGES{1'b1}};
            r_rd_prev  <= 1'b1;
            r_rd_armed <= 1'b0;
            r_rd_idx   <= 3'd0;
            r_oe       <= 1'b0;
            r_dout     <= 16'h0000;
        end else begin
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], lcd_rd_n};
            r_rd_prev <= w_rd_n;
            if (w_soft_rst) begin
                r_rd_armed <= 1'b0;
                r_rd_idx   <= 3'd0;
            end else if (w_arm) begin
                r_rd_armed <= 1'b1;
                r_rd_idx   <= 3'd0;
            end else if (w_disarm) begin
                r_rd_armed <= 1'b0;
            end else if (w_rd_fall && r_rd_idx != 3'd4) begin
                r_rd_idx <= r_rd_idx + 3'd1;
            end
            if (w_rd_fall) begin
                r_oe   <= 1'b1;
                r_dout <= rdid4_word(r_rd_idx);
            end else if (w_rd_rise) begin
                r_oe   <= 1'b0;
                r_dout <= 16'h0000;
            end
        end
    end

    assign lcd_d_out = r_dout;
    assign lcd_d_oe  = r_oe;
`else
    logic w_unused_rd;
    assign w_unused_rd = lcd_rd_n;
    assign lcd_d_out   = 16'h0000;
    assign lcd_d_oe    = 1'b0;
`endif

endmodule

// File: tb/tb_lt24_bus_responder.sv
// Self-checking bench for lt24_bus_responder: directed bus traffic,
// a table of write vectors with expected pixel coordinates, and hand-written
// sequences for latency, overflow, aborted CASET, panel reset and read-back.
module tb_lt24_bus_responder;
    logic        clk = 1'b0;
    logic        reset_n, lcd_cs_n, lcd_dc_n, lcd_wr_n, lcd_rd_n, lcd_reset_n, pix_ready;
    logic [15:0] lcd_d, lcd_d_out, pix_data;
    logic        lcd_d_oe, pix_valid, disp_on, overflow;
    logic [8:0]  pix_x, pix_y;

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] cap_q [$];

    typedef struct {
        logic        dc_n;
        logic [15:0] d;
        logic        has_pix;
        logic [8:0]  ex;
        logic [8:0]  ey;
    } vec_t;
    vec_t vecs [$];

    always #5 clk = ~clk;

    lt24_bus_responder dut (
        .clk(clk), .reset_n(reset_n), .lcd_cs_n(lcd_cs_n), .lcd_dc_n(lcd_dc_n),
        .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n), .lcd_d(lcd_d), .lcd_reset_n(lcd_reset_n),
        .lcd_d_out(lcd_d_out), .lcd_d_oe(lcd_d_oe), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .disp_on(disp_on), .overflow(overflow)
    );

    // Record every accepted pixel, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && pix_valid && pix_ready) cap_q.push_back({pix_x, pix_y, pix_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic dc, input logic [15:0] d);
        lcd_dc_n = dc;
        lcd_d    = d;
        tick(1);
        lcd_wr_n = 1'b0;
        tick(3);
        lcd_wr_n = 1'b1;
        tick(6);
    endtask

    task automatic check_pix(input string name, input logic [8:0] x, input logic [8:0] y, input logic [15:0] rgb);
        logic [33:0] p;
        for (int i = 0; i < 40 && cap_q.size() == 0; i++) @(posedge clk);
        n_checks++;
        if (cap_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no pixel within 40 cycles, expected (%0d,%0d)", name, x, y);
        end else begin
            p = cap_q.pop_front();
            if (p !== {x, y, rgb}) begin
                n_fail++;
                $display("FAIL %s: got (%0d,%0d,0x%04h), expected (%0d,%0d,0x%04h)",
                         name, p[33:25], p[24:16], p[15:0], x, y, rgb);
            end
        end
    endtask

    task automatic add(input logic dc, input logic [15:0] d, input logic hp, input int x, input int y);
        vecs.push_back('{dc, d, hp, 9'(x), 9'(y)});
    endtask

    initial begin
        reset_n = 1'b0; lcd_cs_n = 1'b0; lcd_dc_n = 1'b1; lcd_wr_n = 1'b1; lcd_rd_n = 1'b1;
        lcd_reset_n = 1'b1; lcd_d = 16'h0000; pix_ready = 1'b1;

        // Vectors: CASET 10..11, PASET 5..6, RAMWR x5; then CASET 256..288 -> 239..239.
        add(1'b0, 16'h002A, 1'b0, 0, 0); add(1'b1, 16'h0000, 1'b0, 0, 0);
        add(1'b1, 16'h000A, 1'b0, 0, 0); add(1'b1, 16'h0000, 1'b0, 0, 0);
        add(1'b1, 16'h000B, 1'b0, 0, 0);
        add(1'b0, 16'h002B, 1'b0, 0, 0); add(1'b1, 16'h0000, 1'b0, 0, 0);
        add(1'b1, 16'h0005, 1'b0, 0, 0); add(1'b1, 16'h0000, 1'b0, 0, 0);
        add(1'b1, 16'h0006, 1'b0, 0, 0);
        add(1'b0, 16'h002C, 1'b0, 0, 0);
        add(1'b1, 16'h1111, 1'b1, 10, 5); add(1'b1, 16'h2222, 1'b1, 11, 5);
        add(1'b1, 16'h3333, 1'b1, 10, 6); add(1'b1, 16'h4444, 1'b1, 11, 6);
        add(1'b1, 16'h5555, 1'b1, 10, 5);
        add(1'b0, 16'h002A, 1'b0, 0, 0); add(1'b1, 16'h0001, 1'b0, 0, 0);
        add(1'b1, 16'h0000, 1'b0, 0, 0); add(1'b1, 16'h0001, 1'b0, 0, 0);
        add(1'b1, 16'h0020, 1'b0, 0, 0);
        add(1'b0, 16'h002C, 1'b0, 0, 0);
        add(1'b1, 16'hA001, 1'b1, 239, 5); add(1'b1, 16'hA002, 1'b1, 239, 6);
        add(1'b1, 16'hA003, 1'b1, 239, 5);

        tick(3);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_disp_on",   32'(disp_on),   32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_pix_xy",    32'({pix_x, pix_y, pix_data}), 32'd0);
        check("rst_d_oe",      32'({lcd_d_oe, lcd_d_out}), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Test 1: RAMWR from reset, first-pixel latency.
        bus_write(1'b0, 16'h002C);
        lcd_dc_n = 1'b1; lcd_d = 16'hF800;
        tick(1); lcd_wr_n = 1'b0; tick(3); lcd_wr_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("latency_3clk_low", 32'(pix_valid), 32'd0);
        @(posedge clk);
        #1 check("latency_4clk_high", 32'(pix_valid), 32'd1);
        tick(6);
        bus_write(1'b1, 16'h07E0);
        bus_write(1'b1, 16'h001F);
        check_pix("t1_pix0", 9'd0, 9'd0, 16'hF800);
        check_pix("t1_pix1", 9'd1, 9'd0, 16'h07E0);
        check_pix("t1_pix2", 9'd2, 9'd0, 16'h001F);

        // Tests 2/3: table-driven window programming and wrap.
        foreach (vecs[i]) begin
            bus_write(vecs[i].dc_n, vecs[i].d);
            if (vecs[i].has_pix) check_pix($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].d);
        end

        // disp_on set, then 0x01 clears it and restores the window.
        bus_write(1'b0, 16'h0029);
        check("dispon_set", 32'(disp_on), 32'd1);
        bus_write(1'b0, 16'h0028);
        check("dispoff_clr", 32'(disp_on), 32'd0);
        bus_write(1'b0, 16'h0029);
        bus_write(1'b0, 16'h0001);
        check("swreset_disp", 32'(disp_on), 32'd0);

        // Test 4: overflow with the consumer stalled.
        pix_ready = 1'b0;
        bus_write(1'b0, 16'h002C);
        for (int i = 0; i < 4; i++) bus_write(1'b1, 16'(16'h1000 + i));
        check("full_no_ovf", 32'(overflow), 32'd0);
        bus_write(1'b1, 16'h1004);
        bus_write(1'b1, 16'h1005);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_held_valid", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) check_pix($sformatf("ovf_pix%0d", i), 9'(i), 9'd0, 16'(16'h1000 + i));
        tick(4);
        check("ovf_drained", 32'(cap_q.size()), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        // Pointer kept advancing during the drops: RAMWRC continues at x=6.
        bus_write(1'b0, 16'h003C);
        bus_write(1'b1, 16'hBEEF);
        check_pix("ramwrc_ptr", 9'd6, 9'd0, 16'hBEEF);
        bus_write(1'b0, 16'h0001);
        check("ovf_clr_swreset", 32'(overflow), 32'd0);

        // Test 5: aborted CASET leaves the window unchanged.
        bus_write(1'b0, 16'h002A);
        bus_write(1'b1, 16'h0000);
        bus_write(1'b1, 16'h0005);
        bus_write(1'b0, 16'h002C);
        bus_write(1'b1, 16'h7777);
        check_pix("caset_abort", 9'd0, 9'd0, 16'h7777);

        // Panel reset mid-RAMWR flushes the FIFO and clears disp_on.
        bus_write(1'b0, 16'h0029);
        bus_write(1'b0, 16'h002C);
        pix_ready = 1'b0;
        bus_write(1'b1, 16'h0101);
        bus_write(1'b1, 16'h0202);
        check("pre_lrst_valid", 32'(pix_valid), 32'd1);
        lcd_reset_n = 1'b0;
        tick(5);
        lcd_reset_n = 1'b1;
        tick(4);
        check("lrst_fifo_empty", 32'(pix_valid), 32'd0);
        check("lrst_disp_off", 32'(disp_on), 32'd0);
        pix_ready = 1'b1;
        bus_write(1'b1, 16'h0303);
        tick(4);
        check("idle_data_ignored", 32'(cap_q.size()), 32'd0);

        // reset_n mid-stream discards the FIFO at once.
        pix_ready = 1'b0;
        bus_write(1'b0, 16'h002C);
        bus_write(1'b1, 16'h0404);
        check("pre_rst_valid", 32'(pix_valid), 32'd1);
        reset_n = 1'b0;
        #1 check("async_rst_valid", 32'(pix_valid), 32'd0);
        tick(2);
        reset_n = 1'b1;
        pix_ready = 1'b1;
        tick(2);

        // Test 6: RDID4 read-back.
        bus_write(1'b0, 16'h00D3);
        lcd_dc_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [15:0] exp_d;
`ifdef LT24_RESP_READ_EN
            case (i)
                2:       exp_d = 16'h0093;
                3:       exp_d = 16'h0041;
                default: exp_d = 16'h0000;
            endcase
`else
            exp_d = 16'h0000;
`endif
            lcd_rd_n = 1'b0;
            tick(4);
`ifdef LT24_RESP_READ_EN
            check($sformatf("rd%0d_oe", i), 32'(lcd_d_oe), 32'd1);
`else
            check($sformatf("rd%0d_oe", i), 32'(lcd_d_oe), 32'd0);
`endif
            check($sformatf("rd%0d_data", i), 32'(lcd_d_out), 32'(exp_d));
            lcd_rd_n = 1'b1;
            tick(4);
            check($sformatf("rd%0d_oe_off", i), 32'(lcd_d_oe), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
